// File: rtl/pc_hazard_sequencer.sv
// Fetch-stage sequencer: next-PC select, PC/IF/ID/ID-EX control under a single
// hazard priority, run/halt state machine and saturating stall/flush counters.
module pc_hazard_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic [31:0]      pc_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             mem_busy_i,
    output logic [31:0]      pc_next_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             running_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_MWAIT = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       halt_pend_q, halt_pend_d;
    logic       stall_inc, flush_inc;
    logic       load_use;
    logic [31:0] pc_seq;

    assign pc_seq   = pc_i + 32'd4;
    assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // State and pending-halt registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Next-state and combinational pipeline controls
    always_comb begin
        state_d       = state_q;
        halt_pend_d   = halt_pend_q;
        pc_next_o     = pc_seq;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        running_o     = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pc_next_o = RESET_PC;
                if (start_i) begin
                    state_d = S_RUN;
                end
            end

            S_RUN, S_MWAIT: begin
                running_o     = 1'b1;
                ifid_flush_o  = 1'b0;
                idex_bubble_o = 1'b0;
                // MWAIT freezes only while memory is busy; the release cycle resolves normally
                if (mem_busy_i) begin
                    stall_inc = 1'b1;
                end else if (load_use) begin
                    idex_bubble_o = 1'b1;
                    stall_inc     = 1'b1;
                end else if (branch_taken_i) begin
                    pc_next_o    = branch_target_i;
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    ifid_flush_o = 1'b1;
                    flush_inc    = 1'b1;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                end

                if (!start_i) begin
                    state_d     = S_IDLE;
                    halt_pend_d = 1'b0;
                end else if (state_q == S_RUN) begin
                    if (halt_i) begin
                        state_d = S_HALT;
                    end else if (mem_busy_i) begin
                        state_d = S_MWAIT;
                    end
                end else if (mem_busy_i) begin
                    if (halt_i) begin
                        halt_pend_d = 1'b1;
                    end
                end else begin
                    state_d     = (halt_pend_q || halt_i) ? S_HALT : S_RUN;
                    halt_pend_d = 1'b0;
                end
            end

            S_HALT: begin
                pc_next_o = RESET_PC;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_inc && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_o != {CNT_W{1'b1}})) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_hazard_sequencer.sv
// Scoreboard bench: directed vectors push expected outputs; a negedge monitor
// pops and compares against a default instance and a 4-bit-counter instance.
module tb_pc_hazard_sequencer;

    localparam logic [31:0] RPC = 32'h0000_1000;
    // control bit order: {pc_write, ifid_write, ifid_flush, idex_bubble, running}
    localparam logic [4:0] C_IDLE = 5'b00110;
    localparam logic [4:0] C_RUN  = 5'b11001;
    localparam logic [4:0] C_BR   = 5'b11101;
    localparam logic [4:0] C_LU   = 5'b00011;
    localparam logic [4:0] C_FRZ  = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n, start, halt, br, mr, busy;
    logic [31:0] pc, tgt;
    logic [4:0]  idrt, rs, rt;

    logic [31:0] a_pcn, b_pcn;
    logic        a_pcw, a_ifw, a_fl, a_bub, a_run;
    logic        b_pcw, b_ifw, b_fl, b_bub, b_run;
    logic [15:0] a_st, a_fc;
    logic [3:0]  b_st, b_fc;

    typedef struct {
        string       name;
        logic [31:0] pcn;
        logic [4:0]  ctl;
        logic [15:0] st;
        logic [15:0] fc;
        logic [3:0]  st4;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drv_done = 1'b0;

    always #5 clk = ~clk;

    pc_hazard_sequencer #(.CNT_W(16), .RESET_PC(RPC)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .halt_i(halt), .pc_i(pc),
        .branch_taken_i(br), .branch_target_i(tgt), .idex_memread_i(mr),
        .idex_rt_i(idrt), .ifid_rs_i(rs), .ifid_rt_i(rt), .mem_busy_i(busy),
        .pc_next_o(a_pcn), .pc_write_o(a_pcw), .ifid_write_o(a_ifw),
        .ifid_flush_o(a_fl), .idex_bubble_o(a_bub), .running_o(a_run),
        .stall_cnt_o(a_st), .flush_cnt_o(a_fc)
    );

    pc_hazard_sequencer #(.CNT_W(4), .RESET_PC(RPC)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .halt_i(halt), .pc_i(pc),
        .branch_taken_i(br), .branch_target_i(tgt), .idex_memread_i(mr),
        .idex_rt_i(idrt), .ifid_rs_i(rs), .ifid_rt_i(rt), .mem_busy_i(busy),
        .pc_next_o(b_pcn), .pc_write_o(b_pcw), .ifid_write_o(b_ifw),
        .ifid_flush_o(b_fl), .idex_bubble_o(b_bub), .running_o(b_run),
        .stall_cnt_o(b_st), .flush_cnt_o(b_fc)
    );

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.name, "pc_next",   a_pcn, e.pcn);
                cmp(e.name, "pc_write",  32'(a_pcw), 32'(e.ctl[4]));
                cmp(e.name, "ifid_wr",   32'(a_ifw), 32'(e.ctl[3]));
                cmp(e.name, "flush",     32'(a_fl),  32'(e.ctl[2]));
                cmp(e.name, "bubble",    32'(a_bub), 32'(e.ctl[1]));
                cmp(e.name, "running",   32'(a_run), 32'(e.ctl[0]));
                cmp(e.name, "stall_cnt", 32'(a_st),  32'(e.st));
                cmp(e.name, "flush_cnt", 32'(a_fc),  32'(e.fc));
                cmp(e.name, "w4.pc_next",   b_pcn, e.pcn);
                cmp(e.name, "w4.ctl",       32'({b_pcw, b_ifw, b_fl, b_bub, b_run}), 32'(e.ctl));
                cmp(e.name, "w4.stall_cnt", 32'(b_st), 32'(e.st4));
                cmp(e.name, "w4.flush_cnt", 32'(b_fc), 32'(e.fc[3:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] pcn, input logic [4:0] ctl,
                              input int st, input int fc, input int st4);
        exp_t e;
        e.name = nm; e.pcn = pcn; e.ctl = ctl;
        e.st = 16'(st); e.fc = 16'(fc); e.st4 = 4'(st4);
        sb_q.push_back(e);
    endtask

    task automatic clr();
        halt = 1'b0; br = 1'b0; tgt = 32'h0; mr = 1'b0;
        idrt = 5'd0; rs = 5'd0; rt = 5'd0; busy = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        rst_n = 1'b0; start = 1'b0; pc = 32'h100;
        clr();
        cyc();
        expect_out("reset", RPC, C_IDLE, 0, 0, 0); cyc();
        rst_n = 1'b1; start = 1'b1;
        expect_out("idle_first", RPC, C_IDLE, 0, 0, 0); cyc();
        expect_out("run_seq", 32'h104, C_RUN, 0, 0, 0); cyc();
        mr = 1'b1; idrt = 5'd5; rs = 5'd5;
        expect_out("load_use", 32'h104, C_LU, 0, 0, 0); cyc();
        idrt = 5'd0; rs = 5'd0;
        expect_out("lu_rt_zero", 32'h104, C_RUN, 1, 0, 1); cyc();
        mr = 1'b0; br = 1'b1; tgt = 32'h200;
        expect_out("branch", 32'h200, C_BR, 1, 0, 1); cyc();
        mr = 1'b1; idrt = 5'd7; rt = 5'd7;
        expect_out("br_and_lu", 32'h104, C_LU, 1, 1, 1); cyc();
        clr();
        expect_out("after_lu", 32'h104, C_RUN, 2, 1, 2); cyc();
        busy = 1'b1;
        expect_out("busy1", 32'h104, C_FRZ, 2, 1, 2); cyc();
        expect_out("busy2", 32'h104, C_FRZ, 3, 1, 3); cyc();
        expect_out("busy3", 32'h104, C_FRZ, 4, 1, 4); cyc();
        busy = 1'b0;
        expect_out("mem_release", 32'h104, C_RUN, 5, 1, 5); cyc();
        busy = 1'b1;
        expect_out("busy_b1", 32'h104, C_FRZ, 5, 1, 5); cyc();
        halt = 1'b1;
        expect_out("halt_in_mwait", 32'h104, C_FRZ, 6, 1, 6); cyc();
        halt = 1'b0;
        expect_out("halt_pending", 32'h104, C_FRZ, 7, 1, 7); cyc();
        busy = 1'b0;
        expect_out("release_to_halt", 32'h104, C_RUN, 8, 1, 8); cyc();
        expect_out("halted", RPC, C_IDLE, 8, 1, 8); cyc();
        br = 1'b1;
        expect_out("halt_sticky", RPC, C_IDLE, 8, 1, 8); cyc();
        br = 1'b0; rst_n = 1'b0;
        expect_out("reset2", RPC, C_IDLE, 0, 0, 0); cyc();
        rst_n = 1'b1; pc = 32'hFFFF_FFFC;
        expect_out("idle2", RPC, C_IDLE, 0, 0, 0); cyc();
        expect_out("pc_wrap", 32'h0, C_RUN, 0, 0, 0); cyc();
        start = 1'b0; pc = 32'h300;
        expect_out("stop_cycle", 32'h304, C_RUN, 0, 0, 0); cyc();
        expect_out("stopped", RPC, C_IDLE, 0, 0, 0); cyc();
        start = 1'b1;
        expect_out("restart", RPC, C_IDLE, 0, 0, 0); cyc();
        mr = 1'b1; idrt = 5'd3; rs = 5'd3;
        for (int k = 0; k < 20; k++) begin
            expect_out("sat_stall", 32'h304, C_LU, k, 0, (k > 15) ? 15 : k); cyc();
        end
        clr();
        expect_out("sat_done", 32'h304, C_RUN, 20, 0, 15); cyc();
        halt = 1'b1;
        expect_out("halt_in_run", 32'h304, C_RUN, 20, 0, 15); cyc();
        halt = 1'b0;
        expect_out("halted_run", RPC, C_IDLE, 20, 0, 15); cyc();
        rst_n = 1'b0;
        expect_out("reset3", RPC, C_IDLE, 0, 0, 0); cyc();
        rst_n = 1'b1;
        expect_out("idle3", RPC, C_IDLE, 0, 0, 0); cyc();
        br = 1'b1; tgt = 32'h400;
        expect_out("branch2", 32'h400, C_BR, 0, 0, 0); cyc();
        br = 1'b0; busy = 1'b1;
        expect_out("busy_c1", 32'h304, C_FRZ, 0, 1, 0); cyc();
        expect_out("busy_c2", 32'h304, C_FRZ, 1, 1, 1); cyc();
        rst_n = 1'b0;
        expect_out("async_rst_mwait", RPC, C_IDLE, 0, 0, 0); cyc();
        drv_done = 1'b1;
    end

    // Drain and summary
    initial begin
        int waited;
        waited = 0;
        while (!drv_done && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        repeat (10) begin
            if (sb_q.size() > 0) @(posedge clk);
        end
        total++;
        if (!drv_done || sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0 (driver_done=%0d)", sb_q.size(), drv_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_hazard_sequencer.md
Name: pc_hazard_sequencer

Overview:
- Sequences the fetch stage of the 5-stage pipelined CPU: selects next-PC and drives the PC write enable, IF/ID write/flush and ID/EX bubble.
- Resolves load-use hazards, taken branches and data-memory wait states under a single priority scheme.
- Keeps a run/halt state machine and saturating performance counters for stalls and flushes.
- Sits between the PC register, hazard inputs from the ID/EX stages and the top-level start/halt controls.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters
- RESET_PC, 32'h0000_0000, PC value driven on pc_next_o in IDLE

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-low
- start_i  input  1  level; 1 = CPU may run
- halt_i  input  1  pulse; request stop after the current cycle
- pc_i  input  32  current PC register value
- branch_taken_i  input  1  branch resolved taken in ID
- branch_target_i  input  32  branch target address
- idex_memread_i  input  1  instruction in EX is a load
- idex_rt_i  input  5  load destination register
- ifid_rs_i  input  5  ID source register rs
- ifid_rt_i  input  5  ID source register rt
- mem_busy_i  input  1  data memory not ready; freeze pipeline
- pc_next_o  output  32  next PC value
- pc_write_o  output  1  1 = PC loads pc_next_o
- ifid_write_o  output  1  1 = IF/ID register updates
- ifid_flush_o  output  1  1 = IF/ID loads NOP
- idex_bubble_o  output  1  1 = ID/EX loads control zeros
- running_o  output  1  state is RUN or MWAIT
- stall_cnt_o  output  CNT_W  cycles stalled (load-use plus MWAIT), saturating
- flush_cnt_o  output  CNT_W  branch flushes, saturating

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, both counters 0.
- Reset asserted mid-run aborts immediately; there is no drain.
- States: IDLE, RUN, MWAIT, HALT. The state register is sequential. Control outputs are combinational from the state and the current inputs.
- IDLE: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, pc_next_o=RESET_PC, running_o=0.
  - start_i=1 moves to RUN on the next edge.
- RUN: running_o=1. Events are resolved in this priority order:
  1. halt_i=1: the current cycle's outputs are computed normally; next state is HALT.
  2. mem_busy_i=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0; next state is MWAIT; stall_cnt increments.
  3. Load-use hazard, defined as idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i):
     - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0; stall_cnt increments.
     - A simultaneous branch_taken_i is ignored this cycle. It is re-evaluated next cycle because ID is held.
  4. branch_taken_i=1: pc_next_o=branch_target_i, pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0; flush_cnt increments.
  5. Otherwise: pc_next_o=pc_i+4 (32-bit wrap; 32'hFFFF_FFFC+4 = 0), pc_write_o=1, ifid_write_o=1, flush=0, bubble=0.
- pc_next_o is always driven: branch_target_i when case 4 applies, otherwise pc_i+4. It is only meaningful when pc_write_o=1.
- MWAIT: all writes frozen exactly as in case 2; stall_cnt increments each cycle.
  - On mem_busy_i=0, return to RUN on the next edge. The held hazards are evaluated in RUN.
  - halt_i in MWAIT is latched into a pending flag; the state goes to HALT when mem_busy_i drops.
- HALT: same outputs as IDLE except running_o=0 and counters hold. Exit only via reset.
- start_i=0 in RUN or MWAIT returns to IDLE on the next edge. Counters hold their values. The pending halt flag clears.
- Counters saturate at all-ones and never wrap. A stall and a flush never count in the same cycle.
- Latency: hazard inputs to control outputs is 0 cycles (combinational). State changes take 1 cycle.

Test Plan:
- Reset, then start_i=1 with pc_i=0x100 and no hazards → IDLE outputs during the first cycle, then RUN. pc_next_o=0x104, pc_write_o=1, counters 0.
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for 1 cycle → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, stall_cnt=1. Same with idex_rt_i=0 → no stall.
- Branch: branch_taken_i=1, target=0x200 → pc_next_o=0x200, ifid_flush_o=1, flush_cnt=1. Simultaneous load-use → stall only, flush_cnt unchanged.
- mem_busy_i high for 3 cycles → MWAIT, all writes 0 for 3 cycles, stall_cnt=3, then RUN. halt_i pulsed during MWAIT → HALT after mem_busy_i falls.
- Wrap and saturation: pc_i=0xFFFF_FFFC → pc_next_o=0. CNT_W=4 with 20 stalls → stall_cnt_o=4'hF.
- rst_i dropped asynchronously mid-MWAIT → state=IDLE and counters 0 immediately, before the next clock edge.
